golden_nonce_reporter: RTL and testbench
========================================

Name: golden_nonce_reporter

Overview:
- Downstream of the double-SHA256 hasher pair and golden-ticket compare.
- Accepts a one-cycle golden-ticket pulse with the raw pipeline nonce.
- Subtracts the fixed pipeline offset so the reported nonce is the real one.
- Buffers results in a small FIFO and serialises each as a UART frame to the host, replacing probe-based virtual-wire polling.

Parameters:
- NONCE_OFFSET, 132: pipeline lag subtracted from the raw nonce (mod 2^32).
- FIFO_DEPTH, 4: result FIFO entries; power of two, at least 2.
- CLK_DIV, 434: clk cycles per UART bit (50 MHz / 115200 baud); at least 2.

Ports:
- clk  in  1  hash clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- golden_valid  in  1  one-cycle pulse: hash2 top word is zero.
- golden_nonce_in  in  32  raw nonce, valid when golden_valid=1.
- flush  in  1  new work loaded; discard queued results.
- uart_tx  out  1  serial line, idle high, 8N1, LSB first.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: at least one result dropped.
- busy  out  1  high while a frame is being transmitted.

Behaviour:
- Reset (asynchronous, active-high):
  - uart_tx=1, fifo_count=0, overflow=0, busy=0, FSM=IDLE.
  - FIFO pointers cleared; any in-flight frame is abandoned immediately.
- Offset: stored value = golden_nonce_in - NONCE_OFFSET, 32-bit wrap.
  - Example: 0x00000010 becomes 0xFFFFFF8C.
- Push: golden_valid=1 at an edge writes one entry unless the FIFO is full and no pop occurs that edge.
  - A drop sets overflow, which holds until reset or flush.
- Pop: occurs at an edge where FSM=IDLE and registered fifo_count!=0.
  - The head entry loads the 32-bit shift register; FSM goes to START.
  - Push and pop on the same edge: count unchanged. A push is accepted when full if a pop occurs that edge.
- Frame: 4 bytes, least-significant byte first. Each byte is start(0), 8 data bits LSB first, stop(1).
  - Every bit lasts exactly CLK_DIV cycles, from a down-counter reloaded per bit.
- FSM: IDLE -> START -> DATA (8 bits) -> STOP.
  - STOP -> START if more bytes remain in the frame, otherwise STOP -> IDLE.
  - No idle gap between bytes within a frame. At least one IDLE cycle between frames.
- Latency: push at edge k into an empty FIFO with FSM=IDLE gives pop at edge k+1; uart_tx goes low after edge k+1.
  - The full 4-byte frame occupies 40*CLK_DIV cycles.
- busy=1 from the pop edge until return to IDLE.
- uart_tx is registered; no glitches.
- flush:
  - Clears FIFO pointers and overflow at that edge.
  - A golden_valid on the same edge is discarded, since it belongs to stale work.
  - A frame already in transmission completes unchanged.
- Pulses with golden_valid held high for multiple cycles are treated as one push per cycle. The upstream block guarantees single-cycle pulses.

Optional Feature:
- Macro: GOLDEN_NONCE_SYNC_EN.
- When defined, every frame is preceded by sync byte 0xAA: 5 bytes, 50*CLK_DIV cycles. The host resynchronises on 0xAA.
- When undefined, frames are 4 bytes, no header, timing as above.
- Reset, flush and FIFO behaviour are identical in both builds.

Decomposition:
- Shared package (miner_pkg):
  - NONCE_W=32.
  - UART_BITS_PER_BYTE=10.
  - SYNC_BYTE=8'hAA.
  - FSM state enum (IDLE, START, DATA, STOP).
  - Default NONCE_OFFSET=132.
- One natural sub-module: uart_tx_byte (byte-load/ready handshake, CLK_DIV bit timer, start/stop framing).
  - The top handles the offset, FIFO and byte sequencing.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4):
- Single result: golden_nonce_in=0x00000100 pulse, FIFO empty.
  - uart_tx low after the next edge.
  - Decoded bytes 7C 00 00 00; busy falls after 160 cycles.
- Wrap: golden_nonce_in=0x00000010.
  - Decoded bytes 8C FF FF FF (0xFFFFFF8C).
- Overflow: golden_valid on 6 consecutive edges, nonces 1000..1005, FIFO empty, IDLE.
  - 5 frames transmitted (raw nonces 1000..1004, each minus 132).
  - Sixth dropped; overflow=1; fifo_count peaks at 4.
- Flush mid-frame: flush with 2 queued entries during frame 1, byte 2.
  - Frame 1 completes intact; fifo_count=0, overflow=0; uart_tx idles high after.
- Reset mid-frame: assert reset during a DATA bit, asynchronously and between edges.
  - uart_tx=1 and busy=0 immediately, with no edge required.
  - Next push produces a clean full frame.
- GOLDEN_NONCE_SYNC_EN build: nonce 0x00000100.
  - Decoded bytes AA 7C 00 00 00; busy for 200 cycles.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared constants and the serial transmitter state type for the mining result path.
package miner_pkg;
    localparam int         NONCE_W              = 32;
    localparam int         UART_BITS_PER_BYTE   = 10;
    localparam logic [7:0] SYNC_BYTE            = 8'hAA;
    localparam int         DEFAULT_NONCE_OFFSET = 132;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/golden_nonce_reporter_uart_tx_byte.sv
// 8N1 byte transmitter: load/ready handshake, per-bit down-counter, start/stop framing.
// Loading during the last cycle of a stop bit chains the next byte with no idle gap.
module uart_tx_byte
    import miner_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_tx
);
    localparam int              TW         = $clog2(CLK_DIV);
    localparam logic [TW-1:0]   BIT_RELOAD = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);
    localparam logic [2:0]      LAST_BIT   = 3'(UART_BITS_PER_BYTE - 3);

    tx_state_t     r_state;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit;
    logic          r_tx;
    logic          w_bit_done;

    assign w_bit_done = (r_timer == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_load) begin
                        r_state <= START;
                        r_tx    <= 1'b0;
                        r_timer <= BIT_RELOAD;
                        r_shift <= i_byte;
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= '0;
                        r_timer <= BIT_RELOAD;
                    end else begin
                        r_timer <= r_timer - TIMER_ONE;
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        r_timer <= BIT_RELOAD;
                        if (r_bit == LAST_BIT) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer - TIMER_ONE;
                    end
                end
                STOP: begin
                    if (w_bit_done) begin
                        if (i_load) begin
                            r_state <= START;
                            r_tx    <= 1'b0;
                            r_timer <= BIT_RELOAD;
                            r_shift <= i_byte;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - TIMER_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ready = (r_state == IDLE) || ((r_state == STOP) && w_bit_done);
    assign o_busy  = (r_state != IDLE);
    assign o_tx    = r_tx;
endmodule

// File: rtl/golden_nonce_reporter.sv
// Golden-nonce reporter: offset correction, result FIFO and 4-byte UART framing to the host.
// Define GOLDEN_NONCE_SYNC_EN to prefix every frame with the 0xAA sync byte.
module golden_nonce_reporter
    import miner_pkg::*;
#(
    parameter int NONCE_OFFSET = DEFAULT_NONCE_OFFSET,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLK_DIV      = 434
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        golden_valid,
    input  logic [NONCE_W-1:0]          golden_nonce_in,
    input  logic                        flush,
    output logic                        uart_tx,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic                        busy
);
    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);
    localparam logic [AW:0]    CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]    CNT_MAX = (AW + 1)'(FIFO_DEPTH);
`ifdef GOLDEN_NONCE_SYNC_EN
    localparam logic [2:0]     BYTES_AFTER_FIRST = 3'd4;
`else
    localparam logic [2:0]     BYTES_AFTER_FIRST = 3'd3;
`endif

    logic [NONCE_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               r_overflow;
    logic [NONCE_W-1:0] r_shift;
    logic [2:0]         r_bytes_left;

    logic [NONCE_W-1:0] w_head;
    logic               w_full, w_pop, w_push, w_drop, w_next, w_load;
    logic [7:0]         w_first_byte, w_byte;
    logic               w_tx_ready, w_tx_busy, w_tx;

    assign w_head = r_mem[r_rd_ptr];
    assign w_full = (r_count == CNT_MAX);
    // A flush discards everything queued, so it also blocks a pop and a same-edge push.
    assign w_pop  = !w_tx_busy && (r_count != '0) && !flush;
    assign w_push = golden_valid && !flush && (!w_full || w_pop);
    assign w_drop = golden_valid && !flush && w_full && !w_pop;
    assign w_next = (r_bytes_left != 3'd0) && w_tx_ready && w_tx_busy;
    assign w_load = w_pop || w_next;

`ifdef GOLDEN_NONCE_SYNC_EN
    assign w_first_byte = SYNC_BYTE;
`else
    assign w_first_byte = w_head[7:0];
`endif
    assign w_byte = w_pop ? w_first_byte : r_shift[7:0];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= golden_nonce_in - NONCE_W'(NONCE_OFFSET);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_shift      <= '0;
            r_bytes_left <= '0;
        end else begin
            if (flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
                if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
                else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
                if (w_drop) r_overflow <= 1'b1;
            end
            // The in-flight frame is sequenced independently of flush so it always completes.
            if (w_pop) begin
`ifdef GOLDEN_NONCE_SYNC_EN
                r_shift <= w_head;
`else
                r_shift <= w_head >> 8;
`endif
                r_bytes_left <= BYTES_AFTER_FIRST;
            end else if (w_next) begin
                r_shift      <= r_shift >> 8;
                r_bytes_left <= r_bytes_left - 3'd1;
            end
        end
    end

    uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_byte  (w_byte),
        .o_ready (w_tx_ready),
        .o_busy  (w_tx_busy),
        .o_tx    (w_tx)
    );

    assign uart_tx    = w_tx;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign busy       = w_tx_busy;
endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Directed bench for golden_nonce_reporter with CLK_DIV=4, FIFO_DEPTH=4.
// A free-running receiver decodes uart_tx into a byte queue checked by each test.
module tb_golden_nonce_reporter;
`ifdef GOLDEN_NONCE_SYNC_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        golden_valid = 1'b0;
    logic [31:0] golden_nonce_in = 32'h0;
    logic        flush = 1'b0;
    logic        uart_tx;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    int          rx_err = 0;
    logic [7:0]  rx_q[$];

    always #5 clk = ~clk;

    golden_nonce_reporter #(.NONCE_OFFSET(132), .FIFO_DEPTH(4), .CLK_DIV(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .golden_valid    (golden_valid),
        .golden_nonce_in (golden_nonce_in),
        .flush           (flush),
        .uart_tx         (uart_tx),
        .fifo_count      (fifo_count),
        .overflow        (overflow),
        .busy            (busy)
    );

    // Receiver: detect start, sample mid-bit every 4 cycles, check stop.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0 && reset === 1'b0) begin
                @(negedge clk);
                if (uart_tx !== 1'b0) rx_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (4) @(negedge clk);
                if (uart_tx !== 1'b1) rx_err++;
                rx_q.push_back(b);
            end
        end
    end

    // Expected byte idx of a frame carrying the already-corrected nonce v.
    function automatic logic [7:0] exp_byte(input logic [31:0] v, input int idx);
        int k;
        k = idx;
`ifdef GOLDEN_NONCE_SYNC_EN
        if (k == 0) return 8'hAA;
        k = k - 1;
`endif
        return v[k*8 +: 8];
    endfunction

    task automatic push_one(input logic [31:0] n);
        @(negedge clk);
        golden_valid = 1'b1;
        golden_nonce_in = n;
        @(negedge clk);
        golden_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n;
        n = 0;
        while (!(busy === 1'b0 && fifo_count === 3'd0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= limit) begin
            bad++;
            $display("FAIL %s: idle timeout after %0d cycles, busy=%b count=%0d", name, n, busy, fifo_count);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (uart_tx !== 1'b1)    begin bad++; $display("FAIL rst_tx: got %b expected 1", uart_tx); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (uart_tx !== 1'b1 || busy !== 1'b0)
            begin bad++; $display("FAIL post_rst_idle: got tx=%b busy=%b expected tx=1 busy=0", uart_tx, busy); end
    endtask

    task automatic test_single;
        int n;
        rx_q.delete();
        push_one(32'h0000_0100);
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_queued: got %0d expected 1", fifo_count); end
        total++; if (uart_tx !== 1'b1)    begin bad++; $display("FAIL single_tx_before_pop: got %b expected 1", uart_tx); end
        @(negedge clk);
        total++; if (uart_tx !== 1'b0)    begin bad++; $display("FAIL single_start_bit: got %b expected 0", uart_tx); end
        total++; if (busy !== 1'b1)       begin bad++; $display("FAIL single_busy: got %b expected 1", busy); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL single_popped: got %0d expected 0", fifo_count); end
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        total++; if (n != NB * 40) begin bad++; $display("FAIL single_busy_len: got %0d expected %0d", n, NB * 40); end
        repeat (5) @(negedge clk);
        total++; if (rx_q.size() != NB) begin bad++; $display("FAIL single_nbytes: got %0d expected %0d", rx_q.size(), NB); end
        for (int i = 0; i < NB && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== exp_byte(32'h0000_007C, i))
                begin bad++; $display("FAIL single_byte%0d: got %h expected %h", i, rx_q[i], exp_byte(32'h0000_007C, i)); end
        end
    endtask

    task automatic test_wrap;
        rx_q.delete();
        push_one(32'h0000_0010);
        wait_idle(1000, "wrap_idle");
        total++; if (rx_q.size() != NB) begin bad++; $display("FAIL wrap_nbytes: got %0d expected %0d", rx_q.size(), NB); end
        for (int i = 0; i < NB && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== exp_byte(32'hFFFF_FF8C, i))
                begin bad++; $display("FAIL wrap_byte%0d: got %h expected %h", i, rx_q[i], exp_byte(32'hFFFF_FF8C, i)); end
        end
    endtask

    task automatic test_overflow;
        logic [2:0]  peak;
        logic [31:0] v;
        rx_q.delete();
        peak = 3'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fifo_count > peak) peak = fifo_count;
            golden_valid = 1'b1;
            golden_nonce_in = 32'd1000 + 32'(i);
        end
        @(negedge clk);
        golden_valid = 1'b0;
        if (fifo_count > peak) peak = fifo_count;
        total++; if (overflow !== 1'b1)   begin bad++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        total++; if (peak !== 3'd4)       begin bad++; $display("FAIL ovf_peak: got %0d expected 4", peak); end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
        wait_idle(3000, "ovf_idle");
        repeat (40) @(negedge clk);
        total++; if (rx_q.size() != 5 * NB) begin bad++; $display("FAIL ovf_nbytes: got %0d expected %0d", rx_q.size(), 5 * NB); end
        for (int f = 0; f < 5; f++) begin
            v = 32'h0000_0364 + 32'(f);
            for (int i = 0; i < NB && f * NB + i < rx_q.size(); i++) begin
                total++;
                if (rx_q[f * NB + i] !== exp_byte(v, i))
                    begin bad++; $display("FAIL ovf_f%0d_b%0d: got %h expected %h", f, i, rx_q[f * NB + i], exp_byte(v, i)); end
            end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_flush;
        rx_q.delete();
        @(negedge clk); golden_valid = 1'b1; golden_nonce_in = 32'h0000_0200;
        @(negedge clk); golden_nonce_in = 32'h0000_0300;
        @(negedge clk); golden_nonce_in = 32'h0000_0400;
        @(negedge clk); golden_valid = 1'b0;
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL flush_queued: got %0d expected 2", fifo_count); end
        repeat (50) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL flush_count: got %0d expected 0", fifo_count); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL flush_ovf: got %b expected 0", overflow); end
        total++; if (busy !== 1'b1)       begin bad++; $display("FAIL flush_busy: got %b expected 1", busy); end
        wait_idle(1000, "flush_idle");
        repeat (100) @(negedge clk);
        total++; if (uart_tx !== 1'b1 || busy !== 1'b0)
            begin bad++; $display("FAIL flush_after: got tx=%b busy=%b expected tx=1 busy=0", uart_tx, busy); end
        total++; if (rx_q.size() != NB) begin bad++; $display("FAIL flush_nbytes: got %0d expected %0d", rx_q.size(), NB); end
        for (int i = 0; i < NB && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== exp_byte(32'h0000_017C, i))
                begin bad++; $display("FAIL flush_byte%0d: got %h expected %h", i, rx_q[i], exp_byte(32'h0000_017C, i)); end
        end
        total++; if (rx_err != 0) begin bad++; $display("FAIL framing: got %0d errors expected 0", rx_err); end
    endtask

    task automatic test_reset_mid;
        push_one(32'h0000_0100);
        @(negedge clk);
        repeat (10) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before: got %b expected 1", busy); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (uart_tx !== 1'b1)  begin bad++; $display("FAIL rmid_tx: got %b expected 1", uart_tx); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rmid_ovf: got %b expected 0", overflow); end
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        rx_q.delete();
        rx_err = 0;
        push_one(32'h0000_0100);
        wait_idle(1000, "rmid_idle");
        total++; if (rx_q.size() != NB) begin bad++; $display("FAIL rmid_nbytes: got %0d expected %0d", rx_q.size(), NB); end
        for (int i = 0; i < NB && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== exp_byte(32'h0000_007C, i))
                begin bad++; $display("FAIL rmid_byte%0d: got %h expected %h", i, rx_q[i], exp_byte(32'h0000_007C, i)); end
        end
        total++; if (rx_err != 0) begin bad++; $display("FAIL rmid_framing: got %0d errors expected 0", rx_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_overflow();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
